// File: rtl/soft_oserdes_array.sv
// soft_oserdes_array: lockstep multi-channel fabric serializer with per-word tristate.
// Optional PRBS7 stimulus mode enabled by defining SOFT_OSERDES_PRBS_EN.
module soft_oserdes_array #(
    parameter int   NCH        = 4,
    parameter int   DATA_WIDTH = 8,
    parameter logic INIT       = 1'b0,
    parameter bit   MSB_FIRST  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef SOFT_OSERDES_PRBS_EN
    input  logic                      prbs_en,
`endif
    input  logic [NCH*DATA_WIDTH-1:0] din,
    input  logic [NCH-1:0]            tin,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic [NCH-1:0]            oq,
    output logic [NCH-1:0]            t_out,
    output logic                      busy,
    output logic                      underrun
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);
    localparam int FB = MSB_FIRST ? DW - 1 : 0;

    if (DW != 4 && DW != 8) begin : g_bad_width
        $error("soft_oserdes_array: DATA_WIDTH must be 4 or 8");
    end
    if (NCH < 1 || NCH > 32) begin : g_bad_nch
        $error("soft_oserdes_array: NCH must be 1..32");
    end

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic               buf_full;
    logic [NCH*DW-1:0]  buf_data;
    logic [NCH-1:0]     buf_tin;
    logic [NCH*DW-1:0]  sh, src, src_sh, load_word;
    logic [NCH-1:0]     first, load_tin;
    logic [CW-1:0]      cnt;
    logic               last, load_now, prbs;

`ifdef SOFT_OSERDES_PRBS_EN
    logic [7*NCH-1:0]   lfsr, lfsr_nxt;
    logic [NCH*DW-1:0]  prbs_word;
    logic               pb;
    assign prbs = prbs_en;

    // Advance each channel's PRBS7 (x^7+x^6+1) by one word and gather the bits in shift order
    always_comb begin
        lfsr_nxt  = lfsr;
        prbs_word = '0;
        pb        = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < DW; i++) begin
                pb = lfsr_nxt[c*7+6] ^ lfsr_nxt[c*7+5];
                lfsr_nxt[c*7 +: 7] = {lfsr_nxt[c*7 +: 6], pb};
                prbs_word[c*DW + (MSB_FIRST ? DW-1-i : i)] = pb;
            end
        end
    end

    // LFSR state steps only when a PRBS word is loaded into the shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) lfsr[c*7 +: 7] <= 7'(c + 1);
        end else if (load_now && prbs_en) begin
            lfsr <= lfsr_nxt;
        end
    end

    assign load_word = prbs ? prbs_word : buf_data;
`else
    assign prbs      = 1'b0;
    assign load_word = buf_data;
`endif
    assign load_tin = prbs ? '0 : buf_tin;
    assign busy     = (state == RUN);

    // Handshake, load decision and next state; a draining buffer can refill in the same cycle
    always_comb begin
        last      = (cnt == CW'(DW - 1));
        load_now  = (buf_full || prbs) && (state == IDLE || last);
        din_ready = (!buf_full || load_now) && !prbs;
        state_nxt = load_now ? RUN : (state == RUN && last) ? IDLE : state;
    end

    // Pick the word being presented and compute its first bit and remaining bits
    always_comb begin
        src    = load_now ? load_word : sh;
        first  = '0;
        src_sh = '0;
        for (int c = 0; c < NCH; c++) begin
            first[c]            = src[c*DW + FB];
            src_sh[c*DW +: DW]  = MSB_FIRST ? src[c*DW +: DW] << 1 : src[c*DW +: DW] >> 1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Holding buffer: filled on accept, emptied when the shifter takes it (never in PRBS mode)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            buf_tin  <= '0;
        end else if (din_valid && din_ready) begin
            buf_full <= 1'b1;
            buf_data <= din;
            buf_tin  <= tin;
        end else if (load_now && !prbs) begin
            buf_full <= 1'b0;
        end
    end

    // Shifter and registered pad outputs; running dry returns to INIT and flags underrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oq       <= {NCH{INIT}};
            t_out    <= '1;
            sh       <= '0;
            cnt      <= '0;
            underrun <= 1'b0;
        end else if (load_now) begin
            cnt   <= '0;
            oq    <= first;
            sh    <= src_sh;
            t_out <= load_tin;
        end else if (state == RUN && !last) begin
            cnt <= cnt + CW'(1);
            oq  <= first;
            sh  <= src_sh;
        end else if (state == RUN) begin
            oq       <= {NCH{INIT}};
            t_out    <= '1;
            underrun <= 1'b1;
        end
    end
endmodule
